// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX/MEM shadow state,
// registered forward selects, load-use stall, redirect flush.
module hazard_ctrl #(
    parameter int REG_BITS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ID_Valid,
    input  logic                ID_RegWrite,
    input  logic                ID_MemRead,
    input  logic [REG_BITS-1:0] ID_WriteReg,
    input  logic [REG_BITS-1:0] ID_ReadA,
    input  logic                ID_ReadAValid,
    input  logic [REG_BITS-1:0] ID_ReadB,
    input  logic                ID_ReadBValid,
    input  logic                ID_ALUSrc,
    input  logic                BranchJumpTaken,
    input  logic                MemStall,
    output logic                StallFD,
    output logic                FlushFD,
    output logic                BubbleDX,
    output logic [1:0]          ForwardALUOp1,
    output logic [1:0]          ForwardALUOp2,
    output logic [CNT_W-1:0]    StallCount,
    output logic [CNT_W-1:0]    FlushCount
);

    typedef struct packed {
        logic                v;
        logic                rw;
        logic                ld;
        logic [REG_BITS-1:0] dst;
    } ex_slot_t;

    typedef struct packed {
        logic                v;
        logic                rw;
        logic [REG_BITS-1:0] dst;
    } mem_slot_t;

    ex_slot_t   ex_q;
    mem_slot_t  mem_q;
    logic [1:0] fwd1_q;
    logic [1:0] fwd2_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic use_a;
    logic use_b;
    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic loaduse;
    logic squash;
    logic [1:0] sel1;
    logic [1:0] sel2;

    assign use_a = ID_Valid & ID_ReadAValid;
    assign use_b = ID_Valid & ID_ReadBValid & ~ID_ALUSrc;

    assign ex_hit_a  = ex_q.v & ex_q.rw & (ex_q.dst == ID_ReadA);
    assign ex_hit_b  = ex_q.v & ex_q.rw & (ex_q.dst == ID_ReadB);
    assign mem_hit_a = mem_q.v & mem_q.rw & (mem_q.dst == ID_ReadA);
    assign mem_hit_b = mem_q.v & mem_q.rw & (mem_q.dst == ID_ReadB);

    assign loaduse = ex_q.ld
                   & ((use_a & ex_hit_a) | (use_b & ex_hit_b))
                   & ~BranchJumpTaken;

    assign squash = BranchJumpTaken | loaduse;

    // Youngest producer wins, so the EX hit masks the MEM hit.
    always_comb begin
        sel1 = 2'b00;
        unique case (1'b1)
            use_a & ex_hit_a:               sel1 = 2'b10;
            use_a & mem_hit_a & ~ex_hit_a:  sel1 = 2'b01;
            default:                        sel1 = 2'b00;
        endcase
    end

    always_comb begin
        sel2 = 2'b00;
        unique case (1'b1)
            use_b & ex_hit_b:               sel2 = 2'b10;
            use_b & mem_hit_b & ~ex_hit_b:  sel2 = 2'b01;
            default:                        sel2 = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            fwd1_q <= 2'b00;
            fwd2_q <= 2'b00;
        end else if (!MemStall) begin
            mem_q.v   <= ex_q.v;
            mem_q.rw  <= ex_q.rw;
            mem_q.dst <= ex_q.dst;
            if (squash) begin
                ex_q   <= '0;
                fwd1_q <= 2'b00;
                fwd2_q <= 2'b00;
            end else begin
                ex_q.v   <= ID_Valid;
                ex_q.rw  <= ID_RegWrite;
                ex_q.ld  <= ID_MemRead;
                ex_q.dst <= ID_WriteReg;
                fwd1_q   <= sel1;
                fwd2_q   <= sel2;
            end
        end
    end

    // Debug counters stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!MemStall) begin
            if (loaduse && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (BranchJumpTaken && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign FlushFD       = BranchJumpTaken & ~MemStall;
    assign BubbleDX      = squash & ~MemStall;
    assign StallFD       = loaduse | MemStall;
    assign ForwardALUOp1 = fwd1_q;
    assign ForwardALUOp2 = fwd2_q;
    assign StallCount    = stall_cnt_q;
    assign FlushCount    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, flush,
// memory stall freeze, counter saturation and async reset.
module tb_hazard_ctrl;

    localparam int RB = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_v, id_rw, id_ld;
    logic [RB-1:0] id_wr, id_ra, id_rb;
    logic          id_rav, id_rbv, id_alusrc;
    logic          bjt, ms;
    logic          stall_fd, flush_fd, bubble_dx;
    logic [1:0]    fwd1, fwd2;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_BITS(RB), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_Valid       (id_v),
        .ID_RegWrite    (id_rw),
        .ID_MemRead     (id_ld),
        .ID_WriteReg    (id_wr),
        .ID_ReadA       (id_ra),
        .ID_ReadAValid  (id_rav),
        .ID_ReadB       (id_rb),
        .ID_ReadBValid  (id_rbv),
        .ID_ALUSrc      (id_alusrc),
        .BranchJumpTaken(bjt),
        .MemStall       (ms),
        .StallFD        (stall_fd),
        .FlushFD        (flush_fd),
        .BubbleDX       (bubble_dx),
        .ForwardALUOp1  (fwd1),
        .ForwardALUOp2  (fwd2),
        .StallCount     (stall_cnt),
        .FlushCount     (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic rw, input logic ld,
                       input logic [RB-1:0] wr,
                       input logic [RB-1:0] ra, input logic rav,
                       input logic [RB-1:0] rb, input logic rbv,
                       input logic alusrc, input logic b, input logic m);
        id_v = v; id_rw = rw; id_ld = ld; id_wr = wr;
        id_ra = ra; id_rav = rav; id_rb = rb; id_rbv = rbv;
        id_alusrc = alusrc; bjt = b; ms = m;
        #1;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".stall"}, {31'b0, stall_fd}, 0);
        chk({tag, ".flush"}, {31'b0, flush_fd}, 0);
        chk({tag, ".bubble"}, {31'b0, bubble_dx}, 0);
        chk({tag, ".fwd1"}, {30'b0, fwd1}, 0);
        chk({tag, ".fwd2"}, {30'b0, fwd2}, 0);
        chk({tag, ".scnt"}, {24'b0, stall_cnt}, 0);
        chk({tag, ".fcnt"}, {24'b0, flush_cnt}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        #12;
        all_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
        end
        all_zero("idle");

        // ADD r1 then SUB reading r1 on A: EX/MEM forward
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        chk("fwd_ex.nostall", {31'b0, stall_fd}, 0);
        tick();
        chk("fwd_ex.op1", {30'b0, fwd1}, 2'b10);
        chk("fwd_ex.op2", {30'b0, fwd2}, 2'b00);

        // One independent instruction between: MEM/WB forward
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0); tick();
        chk("fwd_mem.op1", {30'b0, fwd1}, 2'b01);

        // r0 in both EX and MEM: youngest wins
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 6, 0, 1, 0, 1, 0, 0, 0); tick();
        chk("prio.op1", {30'b0, fwd1}, 2'b10);
        chk("prio.op2", {30'b0, fwd2}, 2'b10);

        // LD r2 then ADD reading r2 on B: one stall
        drv(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 6, 0, 0, 2, 1, 0, 0, 0);
        chk("lu.stall", {31'b0, stall_fd}, 1);
        chk("lu.bubble", {31'b0, bubble_dx}, 1);
        chk("lu.flush", {31'b0, flush_fd}, 0);
        tick();
        chk("lu.fwd2_bub", {30'b0, fwd2}, 2'b00);
        chk("lu.scnt", {24'b0, stall_cnt}, 1);
        chk("lu.stall_end", {31'b0, stall_fd}, 0);
        chk("lu.bub_end", {31'b0, bubble_dx}, 0);
        tick();
        chk("lu.fwd2", {30'b0, fwd2}, 2'b01);
        chk("lu.scnt2", {24'b0, stall_cnt}, 1);

        // ADDI r3 then immediate-B consumer of r3
        drv(1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0); tick();
        drv(1, 1, 0, 7, 0, 0, 3, 1, 1, 0, 0);
        chk("imm.stall", {31'b0, stall_fd}, 0);
        tick();
        chk("imm.fwd2", {30'b0, fwd2}, 2'b00);

        // Load r3 then immediate-B consumer: no load-use
        drv(1, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0); tick();
        drv(1, 1, 0, 7, 0, 0, 3, 1, 1, 0, 0);
        chk("immld.stall", {31'b0, stall_fd}, 0);
        tick();
        chk("immld.fwd2", {30'b0, fwd2}, 2'b00);

        // Redirect coinciding with load-use
        drv(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 6, 2, 1, 0, 0, 0, 1, 0);
        chk("br.flush", {31'b0, flush_fd}, 1);
        chk("br.bubble", {31'b0, bubble_dx}, 1);
        chk("br.stall", {31'b0, stall_fd}, 0);
        tick();
        chk("br.fcnt", {24'b0, flush_cnt}, 1);
        chk("br.scnt", {24'b0, stall_cnt}, 1);
        chk("br.fwd1", {30'b0, fwd1}, 2'b00);

        // MemStall freezes a pending EX forward and the counters
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0); tick();
        chk("ms.pre", {30'b0, fwd1}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 1);
            chk("ms.stall", {31'b0, stall_fd}, 1);
            chk("ms.flush", {31'b0, flush_fd}, 0);
            chk("ms.bubble", {31'b0, bubble_dx}, 0);
            tick();
            chk("ms.fwd1", {30'b0, fwd1}, 2'b10);
            chk("ms.fcnt", {24'b0, flush_cnt}, 1);
        end

        // Self-dependent load alternates advance and stall
        for (int i = 0; i < 600; i++) begin
            drv(1, 1, 1, 2, 2, 1, 0, 0, 0, 0, 0);
            tick();
        end
        chk("sat.scnt", {24'b0, stall_cnt}, 32'hFF);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("sat.hold", {24'b0, stall_cnt}, 32'hFF);

        // Reset pulse while a load-use stall is pending
        if (!stall_fd) tick();
        chk("rst.pre", {31'b0, stall_fd}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst.post_stall", {31'b0, stall_fd}, 0);
        chk("rst.post_bub", {31'b0, bubble_dx}, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
